// File: rtl/pgr_uart_cmd_parser.sv
// UART command-frame parser: SYNC, 3 address bytes, 4 data bytes, checksum.
// Issues one command to an MDIO master and waits for its completion pulse.
module pgr_uart_cmd_parser #(
    parameter int          AW        = 24,
    parameter int          DW        = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] GAP_MAX   = 16'd50000,
    parameter logic [23:0] WAIT_MAX  = 24'd1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          cmd_en,
    input  logic          cmd_done,
    output logic          busy,
    output logic          frame_err,
    output logic          timeout_err,
    output logic          overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_WAIT
    } state_e;

    state_e        state_q,       state_d;
    logic [1:0]    byte_cnt_q,    byte_cnt_d;
    logic [7:0]    csum_q,        csum_d;
    logic [AW-1:0] addr_sr_q,     addr_sr_d;
    logic [DW-1:0] data_sr_q,     data_sr_d;
    logic [15:0]   gap_cnt_q,     gap_cnt_d;
    logic [23:0]   wait_cnt_q,    wait_cnt_d;
    logic [AW-1:0] addr_q,        addr_d;
    logic [DW-1:0] data_q,        data_d;
    logic          cmd_en_q,      cmd_en_d;
    logic          busy_q;
    logic          frame_err_q,   frame_err_d;
    logic          timeout_err_q, timeout_err_d;
    logic          overrun_q,     overrun_d;
    logic          gap_expire;
    logic          wait_expire;

    assign gap_expire  = (gap_cnt_q == GAP_MAX - 16'd1);
    assign wait_expire = (wait_cnt_q == WAIT_MAX - 24'd1);

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        csum_d        = csum_q;
        addr_sr_d     = addr_sr_q;
        data_sr_d     = data_sr_q;
        gap_cnt_d     = gap_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        cmd_en_d      = 1'b0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        overrun_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d    = S_ADDR;
                    byte_cnt_d = 2'd0;
                    csum_d     = 8'd0;
                    gap_cnt_d  = 16'd0;
                end
            end

            S_ADDR: begin
                if (rx_valid) begin
                    addr_sr_d  = {addr_sr_q[AW-9:0], rx_data};
                    csum_d     = csum_q + rx_data;
                    gap_cnt_d  = 16'd0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd2) begin
                        state_d    = S_DATA;
                        byte_cnt_d = 2'd0;
                    end
                end else if (gap_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end

            S_DATA: begin
                if (rx_valid) begin
                    data_sr_d  = {data_sr_q[DW-9:0], rx_data};
                    csum_d     = csum_q + rx_data;
                    gap_cnt_d  = 16'd0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = S_CSUM;
                        byte_cnt_d = 2'd0;
                    end
                end else if (gap_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end

            S_CSUM: begin
                if (rx_valid) begin
                    gap_cnt_d = 16'd0;
                    if (rx_data == csum_q) begin
                        addr_d     = addr_sr_q;
                        data_d     = data_sr_q;
                        cmd_en_d   = 1'b1;
                        wait_cnt_d = 24'd0;
                        state_d    = S_WAIT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else if (gap_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end

            S_WAIT: begin
                overrun_d = rx_valid;
                // A done pulse coincident with cmd_en belongs to a previous command.
                if (cmd_done && !cmd_en_q) begin
                    state_d = S_IDLE;
                end else if (wait_expire) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 24'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= 2'd0;
            csum_q        <= 8'd0;
            addr_sr_q     <= '0;
            data_sr_q     <= '0;
            gap_cnt_q     <= 16'd0;
            wait_cnt_q    <= 24'd0;
            addr_q        <= '0;
            data_q        <= '0;
            cmd_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            csum_q        <= csum_d;
            addr_sr_q     <= addr_sr_d;
            data_sr_q     <= data_sr_d;
            gap_cnt_q     <= gap_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            cmd_en_q      <= cmd_en_d;
            busy_q        <= (state_d != S_IDLE);
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign addr        = addr_q;
    assign data        = data_q;
    assign cmd_en      = cmd_en_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule
